// File: rtl/spi_rx_frm.sv
// SPI receive framer in the SCLK domain.
// Deserialises MOSI into fixed frames and hands them over by toggle/ack.
module spi_rx_frm #(
  parameter int FRM_BITS = 24,
  parameter int CMD_W    = 8,
  parameter int DATA_W   = 8,
  parameter int CRC_W    = 8,
  parameter int CNT_W    = 6
) (
  input  logic                i_spi_sclk,
  input  logic                i_rst_n,
  input  logic                i_spi_csb,
  input  logic                i_spi_mosi,
  input  logic                i_frm_ack_tgl,
  input  logic                i_err_clr,
  output logic [FRM_BITS-1:0] o_frm_data,
  output logic [CMD_W-1:0]    o_frm_cmd,
  output logic                o_frm_tgl,
  output logic [CNT_W-1:0]    o_bit_cnt,
  output logic                o_short_err,
  output logic                o_long_err,
  output logic                o_ovr_err
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRM_BITS + 1);

  if ((CMD_W + DATA_W + CRC_W) != FRM_BITS ||
      (2 ** CNT_W) <= FRM_BITS) begin : g_bad_cfg
    $error("spi_rx_frm: inconsistent field/counter widths");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FULL,
    S_OVFL
  } state_e;

  state_e              state_q;
  logic                sof_pend_q;
  logic                sof_rst_n;
  logic                ack_s1_q;
  logic                ack_s2_q;
  logic                clr_s1_q;
  logic                clr_s2_q;
  logic [FRM_BITS-1:0] shreg_q;
  logic [FRM_BITS-1:0] frm_d;
  logic                pending;

  assign sof_rst_n = i_rst_n & ~i_spi_csb;
  assign pending   = o_frm_tgl ^ ack_s2_q;
  assign frm_d     = {shreg_q[FRM_BITS-2:0], i_spi_mosi};
  assign o_frm_cmd = o_frm_data[FRM_BITS-1 -: CMD_W];

  // Start-of-frame marker: armed whenever CSB is high, consumed by first edge
  always_ff @(posedge i_spi_sclk or negedge sof_rst_n) begin
    if (!sof_rst_n) begin
      sof_pend_q <= 1'b1;
    end else begin
      sof_pend_q <= 1'b0;
    end
  end

  // Two-flop synchronisers for the i_clk-domain ack toggle and error clear
  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
    end else begin
      ack_s1_q <= i_frm_ack_tgl;
      ack_s2_q <= ack_s1_q;
      clr_s1_q <= i_err_clr;
      clr_s2_q <= clr_s1_q;
    end
  end

  // Framing FSM, bit counter, publish register and sticky error flags
  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      o_bit_cnt   <= '0;
      o_frm_data  <= '0;
      o_frm_tgl   <= 1'b0;
      o_short_err <= 1'b0;
      o_long_err  <= 1'b0;
      o_ovr_err   <= 1'b0;
    end else if (!i_spi_csb) begin
      if (clr_s2_q) begin
        o_short_err <= 1'b0;
        o_long_err  <= 1'b0;
        o_ovr_err   <= 1'b0;
      end
      if (sof_pend_q) begin
        if (state_q == S_SHIFT && o_bit_cnt != '0 && !clr_s2_q) begin
          o_short_err <= 1'b1;
        end
        shreg_q   <= {{(FRM_BITS-1){1'b0}}, i_spi_mosi};
        o_bit_cnt <= CNT_ONE;
        state_q   <= S_SHIFT;
      end else begin
        unique case (state_q)
          S_SHIFT: begin
            shreg_q   <= frm_d;
            o_bit_cnt <= o_bit_cnt + CNT_ONE;
            if (o_bit_cnt == CNT_LAST) begin
              state_q <= S_FULL;
              if (!pending) begin
                o_frm_data <= frm_d;
                o_frm_tgl  <= ~o_frm_tgl;
              end else if (!clr_s2_q) begin
                o_ovr_err <= 1'b1;
              end
            end
          end
          S_FULL: begin
            if (!clr_s2_q) begin
              o_long_err <= 1'b1;
            end
            o_bit_cnt <= CNT_OVF;
            state_q   <= S_OVFL;
          end
          S_OVFL: begin
            o_bit_cnt <= CNT_OVF;
          end
          S_IDLE: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_frm.sv
// Bench for spi_rx_frm: directed frames, published frames
// checked by a toggle-driven scoreboard monitor.
module tb_spi_rx_frm;

  logic        clk;
  logic        i_rst_n;
  logic        i_spi_csb;
  logic        i_spi_mosi;
  logic        i_frm_ack_tgl;
  logic        i_err_clr;
  logic [23:0] o_frm_data;
  logic [7:0]  o_frm_cmd;
  logic        o_frm_tgl;
  logic [5:0]  o_bit_cnt;
  logic        o_short_err;
  logic        o_long_err;
  logic        o_ovr_err;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  cmd;
  } frm_t;

  frm_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  spi_rx_frm dut (
    .i_spi_sclk    (clk),
    .i_rst_n       (i_rst_n),
    .i_spi_csb     (i_spi_csb),
    .i_spi_mosi    (i_spi_mosi),
    .i_frm_ack_tgl (i_frm_ack_tgl),
    .i_err_clr     (i_err_clr),
    .o_frm_data    (o_frm_data),
    .o_frm_cmd     (o_frm_cmd),
    .o_frm_tgl     (o_frm_tgl),
    .o_bit_cnt     (o_bit_cnt),
    .o_short_err   (o_short_err),
    .o_long_err    (o_long_err),
    .o_ovr_err     (o_ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic [7:0] c);
    frm_t f;
    f.data = d;
    f.cmd  = c;
    exp_q.push_back(f);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    i_spi_csb  = 1'b0;
    i_spi_mosi = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      i_spi_csb  = 1'b1;
      i_spi_mosi = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n       = 1'b0;
    i_spi_csb     = 1'b1;
    i_spi_mosi    = 1'b0;
    i_frm_ack_tgl = 1'b0;
    i_err_clr     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  task automatic chk_errs(input string nm, input logic s,
                          input logic l, input logic o);
    chk({nm, "_short"}, {31'd0, o_short_err}, {31'd0, s});
    chk({nm, "_long"},  {31'd0, o_long_err},  {31'd0, l});
    chk({nm, "_ovr"},   {31'd0, o_ovr_err},   {31'd0, o});
  endtask

  // Scoreboard monitor: each toggle change must match the next queued frame
  initial begin
    logic last;
    frm_t e;
    last = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!i_rst_n) begin
        last = o_frm_tgl;
      end else if (o_frm_tgl !== last) begin
        last = o_frm_tgl;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got frame %0h want none",
                   o_frm_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {8'd0, o_frm_data}, {8'd0, e.data});
          chk("sb_cmd", {24'd0, o_frm_cmd}, {24'd0, e.cmd});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    i_rst_n       = 1'b0;
    i_spi_csb     = 1'b1;
    i_spi_mosi    = 1'b0;
    i_frm_ack_tgl = 1'b0;
    i_err_clr     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_data", {8'd0, o_frm_data}, 32'h0);
    chk("rst_tgl", {31'd0, o_frm_tgl}, 32'h0);
    chk("rst_cnt", {26'd0, o_bit_cnt}, 32'h0);
    chk_errs("rst", 1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b1;

    // single frame, no ack
    push(24'h853CE1, 8'h85);
    send_bits(32'h853CE1, 24);
    chk("t1_data", {8'd0, o_frm_data}, 32'h853CE1);
    chk("t1_cmd", {24'd0, o_frm_cmd}, 32'h85);
    chk("t1_tgl", {31'd0, o_frm_tgl}, 32'h1);
    chk("t1_cnt", {26'd0, o_bit_cnt}, 32'd24);
    chk_errs("t1", 1'b0, 1'b0, 1'b0);
    gap(2);

    // back-to-back with ack
    do_reset();
    push(24'h853CE1, 8'h85);
    push(24'h0A0077, 8'h0A);
    send_bits(32'h853CE1, 24);
    chk("t2_tgl1", {31'd0, o_frm_tgl}, 32'h1);
    i_frm_ack_tgl = 1'b1;
    gap(3);
    send_bits(32'h0A0077, 24);
    chk("t2_data", {8'd0, o_frm_data}, 32'h0A0077);
    chk("t2_tgl", {31'd0, o_frm_tgl}, 32'h0);
    chk("t2_ovr", {31'd0, o_ovr_err}, 32'h0);
    gap(2);

    // back-to-back without ack: second dropped
    do_reset();
    push(24'h853CE1, 8'h85);
    send_bits(32'h853CE1, 24);
    gap(2);
    send_bits(32'h0A0077, 23);
    chk("t3_ovr_pre", {31'd0, o_ovr_err}, 32'h0);
    send_bit(1'b1);
    chk("t3_data", {8'd0, o_frm_data}, 32'h853CE1);
    chk("t3_tgl", {31'd0, o_frm_tgl}, 32'h1);
    chk("t3_ovr", {31'd0, o_ovr_err}, 32'h1);
    gap(2);

    // 26-bit window
    do_reset();
    push(24'h853CE1, 8'h85);
    send_bits(32'h853CE1, 24);
    chk("t4_tgl", {31'd0, o_frm_tgl}, 32'h1);
    chk("t4_long24", {31'd0, o_long_err}, 32'h0);
    send_bit(1'b1);
    chk("t4_long25", {31'd0, o_long_err}, 32'h1);
    chk("t4_cnt25", {26'd0, o_bit_cnt}, 32'd25);
    send_bit(1'b1);
    chk("t4_cnt26", {26'd0, o_bit_cnt}, 32'd25);
    chk("t4_data", {8'd0, o_frm_data}, 32'h853CE1);
    chk("t4_tgl26", {31'd0, o_frm_tgl}, 32'h1);
    gap(2);

    // 10-bit window then good frame
    do_reset();
    send_bits(32'h2AA, 10);
    chk("t5_cnt10", {26'd0, o_bit_cnt}, 32'd10);
    gap(2);
    chk("t5_cnt_hold", {26'd0, o_bit_cnt}, 32'd10);
    chk("t5_short_pre", {31'd0, o_short_err}, 32'h0);
    push(24'h0A0077, 8'h0A);
    send_bit(1'b0);
    chk("t5_short", {31'd0, o_short_err}, 32'h1);
    chk("t5_cnt1", {26'd0, o_bit_cnt}, 32'd1);
    send_bits(32'h0A0077, 23);
    chk("t5_data", {8'd0, o_frm_data}, 32'h0A0077);
    chk("t5_tgl", {31'd0, o_frm_tgl}, 32'h1);
    gap(2);

    // raise all sticky flags, then clear them inside the window
    send_bits(32'h853CE1, 24);
    send_bit(1'b0);
    chk_errs("t6_set", 1'b1, 1'b1, 1'b1);
    chk("t6_data", {8'd0, o_frm_data}, 32'h0A0077);
    i_err_clr = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    chk("t6_lat2", {31'd0, o_long_err}, 32'h1);
    send_bit(1'b0);
    chk_errs("t6_clr", 1'b0, 1'b0, 1'b0);
    i_err_clr = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    chk_errs("t6_after", 1'b0, 1'b0, 1'b0);
    chk("t6_cnt", {26'd0, o_bit_cnt}, 32'd25);
    gap(2);

    // reset mid-frame at bit 12, then frame starts with CSB still low
    send_bits(32'h0A0, 12);
    chk("t7_cnt12", {26'd0, o_bit_cnt}, 32'd12);
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    chk("t7_rst_data", {8'd0, o_frm_data}, 32'h0);
    chk("t7_rst_tgl", {31'd0, o_frm_tgl}, 32'h0);
    chk("t7_rst_cnt", {26'd0, o_bit_cnt}, 32'h0);
    @(posedge clk);
    #3;
    i_rst_n = 1'b1;
    push(24'h853CE1, 8'h85);
    send_bits(32'h853CE1, 24);
    chk("t7_data", {8'd0, o_frm_data}, 32'h853CE1);
    chk("t7_tgl", {31'd0, o_frm_tgl}, 32'h1);
    chk("t7_cnt", {26'd0, o_bit_cnt}, 32'd24);
    chk_errs("t7", 1'b0, 1'b0, 1'b0);
    gap(4);

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
